// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding and default widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int INC_W_DEF  = 3;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2,
    HALTED  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_adder.sv
// PC incrementer: adds a zero-extended step to the PC and reports the carry out.
module pc_adder #(
  parameter int ADDR_W = 8,
  parameter int INC_W  = 3
) (
  input  logic [ADDR_W-1:0] a,
  input  logic [INC_W-1:0]  b,
  output logic [ADDR_W-1:0] y,
  output logic              carry
);

  logic [ADDR_W:0] sum_s;

  assign sum_s      = {1'b0, a} + {{(ADDR_W + 1 - INC_W){1'b0}}, b};
  assign {carry, y} = sum_s;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: presents the PC to fetch over valid/ready, advances by a
// run-time step, takes relative/absolute redirects, stalls, halts and resumes.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INC_W    = INC_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INC_W-1:0]  inc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  input  logic              pc_ready,
  input  logic              br_valid,
  input  logic              br_abs,
  input  logic [ADDR_W-1:0] br_val,
  input  logic              halt,
  input  logic              resume,
  output logic              halted,
  output logic              wrap
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              wrap_q, wrap_d;
  logic              halt_pend_q, halt_pend_d;

  logic [ADDR_W-1:0] inc_pc_s;
  logic              inc_carry_s;
  logic [ADDR_W-1:0] br_pc_s;
  logic              hs_s;
  logic              pend_s;

  pc_adder #(
    .ADDR_W(ADDR_W),
    .INC_W (INC_W)
  ) u_pc_adder (
    .a    (pc_q),
    .b    (inc),
    .y    (inc_pc_s),
    .carry(inc_carry_s)
  );

  assign br_pc_s = br_abs ? br_val : (pc_q + br_val);
  assign hs_s    = valid_q & pc_ready;
  // A halt request is remembered until the outstanding PC is consumed or a branch lands.
  assign pend_s  = halt | halt_pend_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    wrap_d      = wrap_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN, STALLED: begin
        if (br_valid || hs_s) begin
          if (br_valid) begin
            pc_d = br_pc_s;
          end else begin
            pc_d   = inc_pc_s;
            wrap_d = wrap_q | inc_carry_s;
          end
          if (pend_s) begin
            state_d     = HALTED;
            valid_d     = 1'b0;
            halted_d    = 1'b1;
            halt_pend_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d     = STALLED;
          halt_pend_d = pend_s;
        end
      end
      HALTED: begin
        if (resume && !halt) begin
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d  = BOOT;
        pc_d     = RESET_PC;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      wrap_q      <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      wrap_q      <= wrap_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = valid_q;
  assign halted   = halted_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC=8'h10; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] inc;
  logic [7:0] pc_out;
  logic       pc_valid;
  logic       pc_ready;
  logic       br_valid;
  logic       br_abs;
  logic [7:0] br_val;
  logic       halt;
  logic       resume;
  logic       halted;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(
    .ADDR_W  (8),
    .INC_W   (3),
    .RESET_PC(8'h10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (inc),
    .pc_out  (pc_out),
    .pc_valid(pc_valid),
    .pc_ready(pc_ready),
    .br_valid(br_valid),
    .br_abs  (br_abs),
    .br_val  (br_val),
    .halt    (halt),
    .resume  (resume),
    .halted  (halted),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [7:0] exp_pc, input logic exp_valid,
                        input logic exp_halted, input logic exp_wrap);
    chk({tag, ".pc"},     pc_out,            exp_pc);
    chk({tag, ".valid"},  {7'd0, pc_valid},  {7'd0, exp_valid});
    chk({tag, ".halted"}, {7'd0, halted},    {7'd0, exp_halted});
    chk({tag, ".wrap"},   {7'd0, wrap},      {7'd0, exp_wrap});
  endtask

  task automatic branch(input logic abs_i, input logic [7:0] val);
    br_valid = 1'b1;
    br_abs   = abs_i;
    br_val   = val;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inc = 3'd3; pc_ready = 1'b1;
    br_valid = 1'b0; br_abs = 1'b0; br_val = 8'h00;
    halt = 1'b0; resume = 1'b0;
    repeat (3) tick();

    // 1: reset, one BOOT cycle, then 10,13,16
    chk_pc("reset", 8'h10, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2;
    chk_pc("boot", 8'h10, 1'b0, 1'b0, 1'b0);
    tick();
    chk_pc("run0", 8'h10, 1'b1, 1'b0, 1'b0);
    tick();
    chk_pc("run1", 8'h13, 1'b1, 1'b0, 1'b0);
    tick();
    chk_pc("run2", 8'h16, 1'b1, 1'b0, 1'b0);

    // 2: wrap-around from FE by 3, wrap is sticky
    branch(1'b1, 8'hFE);
    chk_pc("to_fe", 8'hFE, 1'b1, 1'b0, 1'b0);
    tick();
    chk_pc("wrap", 8'h01, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("wrap_sticky", {7'd0, wrap}, 8'd1);
    end
    chk("pc_after_20", pc_out, 8'h3D);

    // 3: stall at 20 for 5 cycles, then 21; inc=0 repeats
    branch(1'b1, 8'h20);
    chk("to_20", pc_out, 8'h20);
    pc_ready = 1'b0; inc = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_pc("stall", 8'h20, 1'b1, 1'b0, 1'b1);
    end
    pc_ready = 1'b1;
    tick();
    chk("unstall", pc_out, 8'h21);
    inc = 3'd0;
    tick();
    chk("inc_zero", pc_out, 8'h21);
    inc = 3'd1;

    // 4: branch beats increment on a handshake cycle
    branch(1'b1, 8'h40);
    chk("to_40", pc_out, 8'h40);
    branch(1'b0, 8'hF0);
    chk_pc("rel_neg16", 8'h30, 1'b1, 1'b0, 1'b1);
    branch(1'b1, 8'h80);
    chk_pc("abs_80", 8'h80, 1'b1, 1'b0, 1'b1);
    tick();
    chk("after_br", pc_out, 8'h81);

    // 5: halt while stalled, completes on handshake, resume
    branch(1'b1, 8'h50);
    chk("to_50", pc_out, 8'h50);
    pc_ready = 1'b0;
    tick();
    chk_pc("stall50", 8'h50, 1'b1, 1'b0, 1'b1);
    halt = 1'b1;
    tick();
    chk_pc("halt_pend", 8'h50, 1'b1, 1'b0, 1'b1);
    pc_ready = 1'b1;
    tick();
    chk_pc("halted", 8'h51, 1'b0, 1'b1, 1'b1);
    halt = 1'b0;
    tick();
    chk_pc("halted_hold", 8'h51, 1'b0, 1'b1, 1'b1);
    branch(1'b1, 8'h99);
    chk_pc("halted_br_ign", 8'h51, 1'b0, 1'b1, 1'b1);
    halt = 1'b1; resume = 1'b1;
    tick();
    chk_pc("halt_and_resume", 8'h51, 1'b0, 1'b1, 1'b1);
    halt = 1'b0;
    tick();
    resume = 1'b0;
    chk_pc("resumed", 8'h51, 1'b1, 1'b0, 1'b1);
    tick();
    chk("post_resume", pc_out, 8'h52);

    // 6: asynchronous reset while stalled at 77; branch ignored in BOOT
    branch(1'b1, 8'h77);
    pc_ready = 1'b0;
    tick();
    chk_pc("stall77", 8'h77, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_pc("async_rst", 8'h10, 1'b0, 1'b0, 1'b0);
    br_valid = 1'b1; br_abs = 1'b1; br_val = 8'hAA; pc_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk_pc("boot_br_ign", 8'h10, 1'b1, 1'b0, 1'b0);
    br_valid = 1'b0;
    tick();
    chk("run_after_rst", pc_out, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
